frame_writer: RTL and testbench
===============================

Name: frame_writer

Overview:
- Writer end of the sample stream: accepts 64-bit samples from a streaming source (file reader in sim, ADC front end in silicon) over a valid/ready handshake.
- Stores samples into an N-deep frame buffer. Zero-pads short frames terminated by an end-of-stream flag.
- Holds the completed frame for random-access readback by the FFT core, then releases the buffer for the next frame.

Parameters:
N, 100, samples per frame / buffer depth
W, 64, sample width in bits
AW, $clog2(N), address width
LW, $clog2(N+1), frame-length width

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
in_data  input  W  stream sample
in_valid  input  1  in_data valid this cycle
in_end  input  1  end of stream; level, sampled only in FILL
in_ready  output  1  block accepts a sample this cycle
rd_en  input  1  readback request
rd_addr  input  AW  readback address
rd_data  output  W  readback data
rd_valid  output  1  rd_data valid
release  input  1  consumer finished with frame; frees buffer
frame_done  output  1  buffer holds a complete frame
frame_len  output  LW  count of real (non-padded) samples in frame
short_frame  output  1  frame was zero-padded

Behaviour:
- Reset (async assert, sync release): state=IDLE, wr_ptr=0.
  - All outputs 0: in_ready, rd_valid, rd_data, frame_done, frame_len, short_frame.
  - Buffer contents not reset.
- States: IDLE, FILL, PAD, FULL.
- IDLE → FILL unconditionally on the first clock after reset release.
- FILL:
  - in_ready=1, decoded from registered state.
  - Accept when in_valid&&in_ready: write mem[wr_ptr]=in_data, wr_ptr++, frame_len++.
  - Accept at wr_ptr==N-1 → FULL, frame_done=1 next cycle, short_frame=0, regardless of in_end.
  - in_end=1 with accept at wr_ptr<N-1 → PAD starting at wr_ptr+1.
  - in_end=1 without accept, wr_ptr>0 → PAD starting at wr_ptr.
  - in_end=1 with wr_ptr==0 and no accept: ignored; stay in FILL (no empty frames).
- PAD:
  - in_ready=0; write 0 to mem[wr_ptr], one address per cycle.
  - After the write at N-1 → FULL; short_frame=1, frame_len unchanged.
- FULL:
  - in_ready=0, frame_done=1.
  - rd_en: rd_data=mem[rd_addr] and rd_valid=1 on the next cycle (1-cycle latency). rd_valid is a 1-cycle pulse per request; back-to-back reads give 1 result/cycle.
  - rd_addr>=N: rd_data=0, rd_valid=1.
  - release → FILL next cycle: wr_ptr=0, frame_len=0, frame_done=0, short_frame=0.
  - Same-cycle rd_en and release: read is honoured (rd_valid next cycle), transition still occurs.
- rd_en outside FULL: ignored; rd_valid stays 0, rd_data holds.
- release outside FULL: ignored.
- in_valid outside FILL: ignored; source must hold data while in_ready=0.
- Reset mid-FILL/PAD/FULL: immediate return to reset values; the partial frame is discarded.
- Counters saturate by construction: wr_ptr never exceeds N-1, frame_len never exceeds N.

Decomposition:
- fft_pkg: N, W constants; typedef logic [W-1:0] sample_t; enum fw_state_t {IDLE, FILL, PAD, FULL}.
- Sub-module frame_ram:
  - Single-port-write / single-port-read synchronous RAM, depth N, width W.
  - 1-cycle registered read.
  - No reset on the array.
- frame_writer holds the FSM, pointers and flags only.

Test Plan:
- Full frame:
  - Stimulus: after reset, stream values 1..100 with in_valid held high.
  - Required: in_ready drops after the 100th accept; frame_done=1, frame_len=100, short_frame=0; reads of addr 0/57/99 return 1/58/100, each one cycle after rd_en.
- Short frame:
  - Stimulus: stream 10..39 (30 samples), assert in_end with the 30th.
  - Required: PAD lasts 70 cycles; then frame_done=1, frame_len=30, short_frame=1; addr 29 reads 39, addr 30 and addr 99 read 0.
- Backpressure and gaps:
  - Stimulus: random in_valid gaps; in_valid kept high after frame completes.
  - Required: exactly 100 writes; no accept while in_ready=0; the 101st sample is accepted only after release.
- Release/reuse:
  - Stimulus: fill frame A (all 0xAAAA), read addr 5, pulse release in the same cycle as that rd_en, then fill frame B (0xBBBB).
  - Required: that read returns 0xAAAA; flags clear next cycle; frame B reads 0xBBBB.
- Edge reads:
  - Stimulus: rd_en in FILL; rd_addr=100 in FULL.
  - Required: no rd_valid in FILL; addr 100 gives rd_valid=1, rd_data=0.
- Mid-operation reset:
  - Stimulus: assert reset_n=0 at sample 50.
  - Required: outputs 0 asynchronously; after release, in_ready=1 one cycle later; a new 100-sample frame completes normally with frame_len=100.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the sample-stream frame buffer.
package fft_pkg;

  localparam int N  = 100;
  localparam int W  = 64;
  localparam int AW = $clog2(N);
  localparam int LW = $clog2(N + 1);

  typedef logic [W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    FULL = 2'd3
  } fw_state_t;

endpackage

// File: rtl/frame_ram.sv
// Frame storage: one write port, one registered read port (1-cycle latency).
// No backpressure; out-of-range read addresses return zero.
module frame_ram #(
  parameter int DEPTH = 100,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the read register is reset so the output is clean out of reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_writer.sv
// Streams samples into an N-deep frame, zero-pads short frames, holds it for readback.
// Readback latency 1 cycle; in_ready is low outside FILL so the source must hold data.
module frame_writer
  import fft_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  sample_t       i_in_data,
  input  logic          i_in_valid,
  input  logic          i_in_end,
  output logic          o_in_ready,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output sample_t       o_rd_data,
  output logic          o_rd_valid,
  input  logic          i_release,
  output logic          o_frame_done,
  output logic [LW-1:0] o_frame_len,
  output logic          o_short_frame
);

  fw_state_t     r_state;
  fw_state_t     w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_frame_len;
  logic          r_short;
  logic          r_rd_valid;

  logic          w_accept;
  logic          w_last;
  logic          w_we;
  sample_t       w_wdata;
  logic          w_re;

  assign w_accept = (r_state == FILL) && i_in_valid;
  assign w_last   = (r_wr_ptr == AW'(N - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An end-of-stream with nothing written yet is ignored: empty frames are never produced.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = FILL;
      FILL: begin
        if (w_accept && w_last) begin
          w_next = FULL;
        end else if (i_in_end && (w_accept || (r_wr_ptr != '0))) begin
          w_next = PAD;
        end
      end
      PAD: begin
        if (w_last) begin
          w_next = FULL;
        end
      end
      FULL: begin
        if (i_release) begin
          w_next = FILL;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready   = 1'b0;
    o_frame_done = 1'b0;
    w_we         = 1'b0;
    w_wdata      = '0;
    w_re         = 1'b0;
    case (r_state)
      FILL: begin
        o_in_ready = 1'b1;
        w_we       = i_in_valid;
        w_wdata    = i_in_data;
      end
      PAD: begin
        w_we = 1'b1;
      end
      FULL: begin
        o_frame_done = 1'b1;
        w_re         = i_rd_en;
      end
      default: begin
      end
    endcase
  end

  // wr_ptr parks at N-1 on the final write, so it never leaves the array.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr    <= '0;
      r_frame_len <= '0;
      r_short     <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_re;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_frame_len <= r_frame_len + LW'(1);
            if (!w_last) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end
          end
        end
        PAD: begin
          if (w_last) begin
            r_short <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
        end
        FULL: begin
          if (i_release) begin
            r_wr_ptr    <= '0;
            r_frame_len <= '0;
            r_short     <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  frame_ram #(
    .DEPTH (N),
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_we      (w_we),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (w_wdata),
    .i_re      (w_re),
    .i_raddr   (i_rd_addr),
    .o_rdata   (o_rd_data)
  );

  assign o_rd_valid    = r_rd_valid;
  assign o_frame_len   = r_frame_len;
  assign o_short_frame = r_short;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: table of frame shapes, directed corner sequences, random gaps vs a queue model.
module tb_frame_writer;
  import fft_pkg::*;

  typedef struct {
    int      n;
    sample_t base;
    bit      use_end;
    int      exp_len;
    bit      exp_short;
    int      exp_pad;
  } vec_t;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  sample_t       in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_end   = 1'b0;
  logic          rd_en    = 1'b0;
  logic          rls      = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic          in_ready;
  logic          rd_valid;
  logic          frame_done;
  logic          short_frame;
  sample_t       rd_data;
  logic [LW-1:0] frame_len;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the frame is just the queue of accepted samples; everything past it reads as zero.
  sample_t m_frame[$];
  int      m_pad_left;
  bit      m_held;
  bit      m_idle;
  bit      m_short;
  bit      m_rd_valid;
  sample_t m_rd_data;
  bit      last_acc;

  always #5 clock = ~clock;

  frame_writer dut (
    .i_clock       (clock),
    .i_reset_n     (reset_n),
    .i_in_data     (in_data),
    .i_in_valid    (in_valid),
    .i_in_end      (in_end),
    .o_in_ready    (in_ready),
    .i_rd_en       (rd_en),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .i_release     (rls),
    .o_frame_done  (frame_done),
    .o_frame_len   (frame_len),
    .o_short_frame (short_frame)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic sample_t exp_read(input int a);
    if (a < N && a < m_frame.size()) return m_frame[a];
    return '0;
  endfunction

  task automatic m_reset();
    m_frame.delete();
    m_pad_left = 0;
    m_held     = 1'b0;
    m_idle     = 1'b1;
    m_short    = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_data  = '0;
  endtask

  task automatic cycle(input bit v, input sample_t d, input bit e,
                       input bit re, input int ra, input bit rel);
    bit rdy_exp;
    in_valid = v;
    in_data  = d;
    in_end   = e;
    rd_en    = re;
    rd_addr  = AW'(ra);
    rls      = rel;
    rdy_exp  = !m_idle && !m_held && (m_pad_left == 0);
    chk("in_ready", in_ready, rdy_exp);
    last_acc = v && rdy_exp;
    if (m_held && re) begin
      m_rd_valid = 1'b1;
      m_rd_data  = exp_read(ra);
    end else begin
      m_rd_valid = 1'b0;
    end
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (rdy_exp) begin
      if (v) m_frame.push_back(d);
      if (m_frame.size() == N) begin
        m_held  = 1'b1;
        m_short = 1'b0;
      end else if (e && m_frame.size() > 0) begin
        m_pad_left = N - m_frame.size();
      end
    end else if (m_pad_left > 0) begin
      m_pad_left--;
      if (m_pad_left == 0) begin
        m_held  = 1'b1;
        m_short = 1'b1;
      end
    end else if (m_held && rel) begin
      m_held  = 1'b0;
      m_short = 1'b0;
      m_frame.delete();
    end
    @(posedge clock);
    #1;
    chk("frame_done", frame_done, m_held);
    chk("frame_len", frame_len, 64'(m_frame.size()));
    chk("short_frame", short_frame, m_short);
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic stream(input int n, input sample_t base, input sample_t step,
                        input bit end_last, input int gap_pct, input bit rnd);
    for (int i = 0; i < n; i++) begin
      sample_t d;
      int      tries;
      d        = rnd ? {$urandom, $urandom} : base + step * sample_t'(i);
      tries    = 0;
      last_acc = 1'b0;
      while (!last_acc) begin
        bit v;
        v = (int'($urandom_range(99)) >= gap_pct);
        cycle(v, d, end_last && (i == n - 1) && v, 1'b0, 0, 1'b0);
        tries++;
        if (!last_acc && tries > 500) begin
          n_chk++;
          n_fail++;
          $display("FAIL stream_timeout: sample %0d not accepted within %0d cycles", i, tries);
          return;
        end
      end
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!frame_done && cnt < 300) begin
      idle_cycle();
      cnt++;
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, a, 1'b0);
    end
    idle_cycle();
  endtask

  task automatic release_frame();
    cycle(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_end   = 1'b0;
    rd_en    = 1'b0;
    rls      = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_short", short_frame, 0);
    m_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[5];
    int   pad;

    tbl[0] = '{100, 64'd1,     1'b0, 100, 1'b0, 0};
    tbl[1] = '{30,  64'd10,    1'b1, 30,  1'b1, 70};
    tbl[2] = '{1,   64'h300,   1'b1, 1,   1'b1, 99};
    tbl[3] = '{99,  64'h4000,  1'b1, 99,  1'b1, 1};
    tbl[4] = '{100, 64'h50000, 1'b1, 100, 1'b0, 0};

    m_reset();
    do_reset();

    // IDLE cycle, then reads / release / empty end-of-stream while filling are all ignored
    cycle(1'b0, '0, 1'b0, 1'b1, 5, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 0, 1'b1);
    chk("empty_end_ignored", in_ready, 1);
    cycle(1'b0, '0, 1'b0, 1'b1, 3, 1'b0);
    chk("fill_rd_valid", rd_valid, 0);

    for (int k = 0; k < 5; k++) begin
      stream(tbl[k].n, tbl[k].base, 64'd1, tbl[k].use_end, 0, 1'b0);
      wait_done(pad);
      chk("tbl_pad_cycles", 64'(pad), 64'(tbl[k].exp_pad));
      chk("tbl_frame_len", frame_len, 64'(tbl[k].exp_len));
      chk("tbl_short", short_frame, tbl[k].exp_short);
      chk("tbl_in_ready", in_ready, 0);
      cycle(1'b0, '0, 1'b0, 1'b1, tbl[k].n - 1, 1'b0);
      chk("tbl_last_sample", rd_data, tbl[k].base + sample_t'(tbl[k].n - 1));
      read_all();
      release_frame();
    end

    // Random gaps, then valid held high against a full buffer
    stream(100, '0, '0, 1'b0, 40, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 64'hDEAD, 1'b0, 1'b0, 0, 1'b0);
    end
    chk("bp_len_100", frame_len, 100);
    read_all();
    cycle(1'b1, 64'h101, 1'b0, 1'b0, 0, 1'b1);
    chk("bp_no_acc_on_release", frame_len, 0);
    cycle(1'b1, 64'h101, 1'b0, 1'b0, 0, 1'b0);
    chk("bp_101st_accept", frame_len, 1);
    stream(99, '0, '0, 1'b0, 20, 1'b1);
    read_all();
    release_frame();

    // Reuse: read in the release cycle, then refill
    stream(100, 64'hAAAA, '0, 1'b0, 0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 5, 1'b1);
    chk("reuse_rd_a", rd_data, 64'hAAAA);
    chk("reuse_rd_valid", rd_valid, 1);
    chk("reuse_done_clr", frame_done, 0);
    chk("reuse_len_clr", frame_len, 0);
    stream(100, 64'hBBBB, '0, 1'b0, 0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 5, 1'b0);
    chk("reuse_rd_b", rd_data, 64'hBBBB);
    cycle(1'b0, '0, 1'b0, 1'b1, 100, 1'b0);
    chk("oob_rd_valid", rd_valid, 1);
    chk("oob_rd_data", rd_data, 0);
    cycle(1'b0, '0, 1'b0, 1'b1, 127, 1'b0);
    release_frame();

    // Reset in the middle of a fill
    stream(50, 64'h5000, 64'd1, 1'b0, 0, 1'b0);
    do_reset();
    idle_cycle();
    chk("ready_after_reset", in_ready, 1);
    stream(100, 64'h7000, 64'd1, 1'b0, 10, 1'b0);
    chk("post_reset_len", frame_len, 100);
    chk("post_reset_done", frame_done, 1);
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
